// File: rtl/btn_debounce_repeat.sv
// Pushbutton conditioner: 2-flop synchroniser, counter debounce, and a
// hold/auto-repeat state machine producing press, release and repeat pulses.
//
// state  | meaning
// IDLE   | button released, no repeat timing
// HOLD   | button held, counting toward the first repeat (held at 0 when rep_en=0)
// REPEAT | auto-repeating, counting the repeat period
module btn_debounce_repeat #(
    parameter int CNT_MAX    = 1000000,
    parameter int CNT_W      = 20,
    parameter int REPEAT_DLY = 50000000,
    parameter int REPEAT_PER = 10000000,
    parameter int RPT_W      = 26
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_in,
    input  logic rep_en,
    output logic btn_level,
    output logic btn_press,
    output logic btn_release,
    output logic btn_repeat
);

    typedef enum logic [1:0] {
        IDLE,
        HOLD,
        REPEAT
    } state_t;

    localparam logic [CNT_W-1:0] CNT_TC = CNT_W'(CNT_MAX - 1);
    localparam logic [RPT_W-1:0] DLY_TC = RPT_W'(REPEAT_DLY - 1);
    localparam logic [RPT_W-1:0] PER_TC = RPT_W'(REPEAT_PER - 1);

    logic             sync_0;
    logic             sync_1;
    logic [CNT_W-1:0] cnt;
    logic [RPT_W-1:0] rcnt;
    logic [RPT_W-1:0] rcnt_next;
    state_t           state;
    state_t           state_next;
    logic             repeat_next;
    logic             flip;
    logic             rise;
    logic             fall;

    // The debounced level flips on the same edge these are high, so the FSM
    // sees press/release edges without waiting for the registered pulses.
    assign flip = (sync_1 != btn_level) && (cnt == CNT_TC);
    assign rise = flip & sync_1;
    assign fall = flip & ~sync_1;

    // Two-flop synchroniser for the asynchronous pad input.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_0 <= 1'b0;
            sync_1 <= 1'b0;
        end else begin
            sync_0 <= btn_in;
            sync_1 <= sync_0;
        end
    end

    // Debounce counter: the level only flips after CNT_MAX consecutive
    // disagreeing samples; any agreement restarts the count.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt         <= '0;
            btn_level   <= 1'b0;
            btn_press   <= 1'b0;
            btn_release <= 1'b0;
        end else begin
            btn_press   <= 1'b0;
            btn_release <= 1'b0;
            if (sync_1 == btn_level) begin
                cnt <= '0;
            end else if (cnt == CNT_TC) begin
                cnt         <= '0;
                btn_level   <= sync_1;
                btn_press   <= sync_1;
                btn_release <= ~sync_1;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

    // Repeat FSM state, repeat counter and registered repeat pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            rcnt       <= '0;
            btn_repeat <= 1'b0;
        end else begin
            state      <= state_next;
            rcnt       <= rcnt_next;
            btn_repeat <= repeat_next;
        end
    end

    // Repeat FSM next state; a release on a terminal-count edge suppresses the
    // repeat pulse because the fall check is taken first.
    always_comb begin
        state_next  = state;
        rcnt_next   = rcnt;
        repeat_next = 1'b0;
        case (state)
            IDLE: begin
                if (rise) begin
                    state_next = HOLD;
                    rcnt_next  = '0;
                end
            end
            HOLD: begin
                if (fall) begin
                    state_next = IDLE;
                    rcnt_next  = '0;
                end else if (!rep_en) begin
                    rcnt_next = '0;
                end else if (rcnt == DLY_TC) begin
                    repeat_next = 1'b1;
                    rcnt_next   = '0;
                    state_next  = REPEAT;
                end else begin
                    rcnt_next = rcnt + RPT_W'(1);
                end
            end
            REPEAT: begin
                if (fall) begin
                    state_next = IDLE;
                    rcnt_next  = '0;
                end else if (!rep_en) begin
                    state_next = HOLD;
                    rcnt_next  = '0;
                end else if (rcnt == PER_TC) begin
                    repeat_next = 1'b1;
                    rcnt_next   = '0;
                end else begin
                    rcnt_next = rcnt + RPT_W'(1);
                end
            end
            default: begin
                state_next = IDLE;
                rcnt_next  = '0;
            end
        endcase
    end

endmodule

// File: doc/btn_debounce_repeat.md
Name: btn_debounce_repeat

Overview:
- Conditions one raw pushbutton for the game control path.
- Stages: 2-flop synchroniser, counter-based debounce, then a hold/auto-repeat state machine.
- Outputs: a clean level, single-cycle press and release pulses, and timed repeat pulses while the button is held (continuous player movement).
- One instance per board button, between the pad and the game FSM.

Parameters:
- CNT_MAX, 1000000: cycles sync_1 must disagree with the stable level before the level flips (10 ms at 100 MHz); legal range >= 2.
- CNT_W, 20: debounce counter width; must hold CNT_MAX-1.
- REPEAT_DLY, 50000000: cycles from the press pulse to the first repeat pulse; legal range >= 2.
- REPEAT_PER, 10000000: cycles between subsequent repeat pulses; legal range >= 2.
- RPT_W, 26: repeat counter width; must hold max(REPEAT_DLY, REPEAT_PER)-1.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- reset  input  1  synchronous active-high reset.
- btn_in  input  1  raw asynchronous pushbutton, 1 = pressed.
- rep_en  input  1  auto-repeat enable, sampled every cycle.
- btn_level  output  1  debounced level.
- btn_press  output  1  one-cycle pulse on debounced 0->1.
- btn_release  output  1  one-cycle pulse on debounced 1->0.
- btn_repeat  output  1  one-cycle auto-repeat pulse.

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-high, named reset. All registers clear only on a rising clk edge with reset=1; reset overrides every other event.
- Reset values: sync_0=0, sync_1=0, btn_level=0, cnt=0, rcnt=0, state=IDLE, all pulse outputs 0.
- Synchroniser: sync_0<=btn_in, sync_1<=sync_0. Nothing downstream reads btn_in or sync_0.
- Debounce when sync_1==btn_level: cnt<=0.
- Debounce when sync_1!=btn_level and cnt!=CNT_MAX-1: cnt<=cnt+1.
- Debounce when sync_1!=btn_level and cnt==CNT_MAX-1: btn_level<=sync_1 and cnt<=0. On that same edge, btn_press<=1 if the new level is 1, else btn_release<=1.
- Glitch handling: any sync_1 return to btn_level before terminal count zeroes cnt; no level change and no pulse.
- Latency: after btn_in changes and stays changed, btn_level and the pulse update on the (CNT_MAX+2)-th rising edge. The first edge sampling the new btn_in counts as 1.
- Pulses are registered, high exactly one cycle. btn_press and btn_release are never high together.
- FSM IDLE: stay while btn_level=0. On the press edge, go to HOLD with rcnt<=0.
- FSM HOLD: rcnt+1 each cycle. At rcnt==REPEAT_DLY-1 with rep_en=1: btn_repeat<=1, rcnt<=0, go to REPEAT.
- FSM HOLD with rep_en=0: rcnt holds at 0; stay in HOLD.
- FSM REPEAT: rcnt+1 each cycle. At rcnt==REPEAT_PER-1: btn_repeat<=1, rcnt<=0.
- FSM REPEAT with rep_en=0: go to HOLD, rcnt<=0.
- Repeat timing: first repeat comes REPEAT_DLY cycles after the press pulse, then every REPEAT_PER cycles.
- Release: on the release edge, from HOLD or REPEAT go to IDLE with rcnt<=0. No btn_repeat on the release edge, even if the terminal count coincides; release wins.
- Counter wrap: neither counter exceeds its terminal value. There is no overflow path.
- Reset mid-operation: everything clears, state IDLE, btn_level=0. If btn_in is still high after reset deasserts, it is re-debounced. A fresh btn_press comes CNT_MAX+2 edges later.
- btn_in changing during reset has no effect beyond the synchroniser flops, which are also held at 0.

Test Plan (CNT_MAX=4, REPEAT_DLY=8, REPEAT_PER=3):
- Reset applied 3 cycles with btn_in=1 -> all outputs 0 during reset. After reset drops, btn_level=1 and btn_press=1 for one cycle on the 6th edge.
- btn_in 0->1 held 30 cycles, rep_en=0 -> btn_press on edge 6, btn_level stays 1, btn_repeat never asserts.
- btn_in high 3 cycles then low, repeated 5 times -> btn_level stays 0, no pulses, cnt returns to 0 each time.
- Press held with rep_en=1 -> btn_press at edge 6, btn_repeat at edges 14, 17, 20, ... each exactly one cycle.
- While repeating, btn_in drops so the debounced release edge lands on a repeat terminal edge -> btn_release=1, btn_repeat=0, state IDLE. The next press restarts the 8-cycle delay.
- Reset asserted for 1 cycle mid-REPEAT with btn_in held 1 -> btn_level falls to 0 with no btn_release pulse. btn_press is re-issued 6 edges after reset drops, and the repeat delay restarts.
